// File: rtl/i2c_burst_sequencer_if.sv
// Command port between the burst sequencer and the I2C master.
// The sequencer uses the master modport; the I2C master (or a model of it)
// uses the slave modport.
interface i2c_burst_sequencer_if;
  logic       m_start;
  logic       m_rw;
  logic [6:0] m_slave_addr;
  logic [7:0] m_tx_data;
  logic       m_busy;
  logic       m_done;
  logic       m_ack_error;
  logic [7:0] m_rx_data;

  modport master (
    output m_start, m_rw, m_slave_addr, m_tx_data,
    input  m_busy, m_done, m_ack_error, m_rx_data
  );

  modport slave (
    input  m_start, m_rw, m_slave_addr, m_tx_data,
    output m_busy, m_done, m_ack_error, m_rx_data
  );
endinterface

// File: rtl/i2c_burst_sequencer.sv
// Burst sequencer in front of the I2C master: one go pulse runs 1-15 writes
// of incrementing bytes to one slave, optionally reading each byte back and
// checking it against written ^ READ_XOR. Results are held until the next go.
module i2c_burst_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter logic [7:0]  READ_XOR       = 8'hFF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         go,
  input  logic [6:0]                   cfg_addr,
  input  logic [7:0]                   cfg_base_data,
  input  logic [3:0]                   cfg_count,
  input  logic                         cfg_verify,
  i2c_burst_sequencer_if.master        m,
  output logic                         busy,
  output logic                         done,
  output logic [4:0]                   pass_cnt,
  output logic [4:0]                   fail_cnt,
  output logic [4:0]                   nack_cnt,
  output logic                         timeout,
  output logic [7:0]                   last_rx
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Value of the wait counter in the last permitted wait cycle.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, NEXT, FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          verify_q, verify_d;
  logic          rw_q, rw_d;
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    tx_q, tx_d;
  logic [4:0]    pass_q, pass_d;
  logic [4:0]    fail_q, fail_d;
  logic [4:0]    nack_q, nack_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    last_rx_q, last_rx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          armed_q, armed_d;

  // Start, busy and done come straight from the state register so reset
  // silences them at once; start is withheld while the master is busy.
  assign m.m_start      = ((state_q == ISSUE_WR) || (state_q == ISSUE_RD)) && !m.m_busy;
  assign m.m_rw         = rw_q;
  assign m.m_slave_addr = addr_q;
  assign m.m_tx_data    = tx_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FINISH);
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign nack_cnt       = nack_q;
  assign timeout        = timeout_q;
  assign last_rx        = last_rx_q;

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      verify_q  <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      tx_q      <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      nack_q    <= '0;
      timeout_q <= 1'b0;
      last_rx_q <= '0;
      tmo_q     <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      verify_q  <= verify_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      nack_q    <= nack_d;
      timeout_q <= timeout_d;
      last_rx_q <= last_rx_d;
      tmo_q     <= tmo_d;
      armed_q   <= armed_d;
    end
  end

  // Next-state and result bookkeeping for the burst FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    verify_d  = verify_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    nack_d    = nack_q;
    timeout_d = timeout_q;
    last_rx_d = last_rx_q;
    tmo_d     = tmo_q;
    armed_d   = armed_q;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          addr_d    = cfg_addr;
          tx_d      = cfg_base_data;
          cnt_d     = cfg_count;
          verify_d  = cfg_verify;
          rw_d      = 1'b0;
          idx_d     = '0;
          pass_d    = '0;
          fail_d    = '0;
          nack_d    = '0;
          timeout_d = 1'b0;
          last_rx_d = '0;
          state_d   = (cfg_count == 4'd0) ? FINISH : ISSUE_WR;
        end
      end

      ISSUE_WR, ISSUE_RD: begin
        if (!m.m_busy) begin
          tmo_d   = '0;
          armed_d = 1'b0;
          state_d = (state_q == ISSUE_WR) ? WAIT_WR : WAIT_RD;
        end
      end

      WAIT_WR, WAIT_RD: begin
        tmo_d = tmo_q + TW'(1);
        // A done that was already high before the master went busy belongs
        // to an earlier transaction, so completion needs busy seen first.
        if (m.m_busy) armed_d = 1'b1;
        if (armed_q && m.m_done) begin
          if (m.m_ack_error) begin
            nack_d  = nack_q + 5'd1;
            fail_d  = fail_q + 5'd1;
            state_d = NEXT;
          end else if (state_q == WAIT_WR) begin
            if (verify_q) begin
              rw_d    = 1'b1;
              state_d = ISSUE_RD;
            end else begin
              pass_d  = pass_q + 5'd1;
              state_d = NEXT;
            end
          end else begin
            last_rx_d = m.m_rx_data;
            if (m.m_rx_data == (tx_q ^ READ_XOR)) pass_d = pass_q + 5'd1;
            else                                   fail_d = fail_q + 5'd1;
            state_d = NEXT;
          end
        end else if (tmo_q == TMO_LAST) begin
          fail_d    = fail_q + 5'd1;
          timeout_d = 1'b1;
          state_d   = FINISH;
        end
      end

      NEXT: begin
        idx_d = idx_q + 4'd1;
        rw_d  = 1'b0;
        if (idx_q + 4'd1 == cnt_q) begin
          state_d = FINISH;
        end else begin
          tx_d    = tx_q + 8'd1;
          state_d = ISSUE_WR;
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_burst_sequencer.sv
// Directed bench for i2c_burst_sequencer with a behavioural I2C master model
// and a queue of expected master transactions.
module tb_i2c_burst_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic [6:0] cfg_addr = '0;
  logic [7:0] cfg_base_data = '0;
  logic [3:0] cfg_count = '0;
  logic       cfg_verify = 1'b0;
  logic       busy, done, timeout;
  logic [4:0] pass_cnt, fail_cnt, nack_cnt;
  logic [7:0] last_rx;

  always #5 clk = ~clk;

  i2c_burst_sequencer_if bus ();

  i2c_burst_sequencer #(
    .TIMEOUT_CYCLES(100),
    .READ_XOR      (8'hFF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (go),
    .cfg_addr     (cfg_addr),
    .cfg_base_data(cfg_base_data),
    .cfg_count    (cfg_count),
    .cfg_verify   (cfg_verify),
    .m            (bus),
    .busy         (busy),
    .done         (done),
    .pass_cnt     (pass_cnt),
    .fail_cnt     (fail_cnt),
    .nack_cnt     (nack_cnt),
    .timeout      (timeout),
    .last_rx      (last_rx)
  );

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
    logic       nack;
    logic [7:0] rx;
  } txn_t;

  txn_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         n_start = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         done_cyc = 0;
  int         stale_delay = 0;
  bit         stale_on = 1'b0;
  bit         silent = 1'b0;
  bit         abort = 1'b0;
  int         exp_pass, exp_fail, exp_nack;
  logic [7:0] exp_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Master model: answers each m_start with a few busy cycles and a done pulse.
  initial begin : master_model
    txn_t e;
    bus.m_busy = 1'b0; bus.m_done = 1'b0; bus.m_ack_error = 1'b0; bus.m_rx_data = '0;
    forever begin
      @(negedge clk);
      bus.m_done = stale_on;
      bus.m_ack_error = stale_on;
      while (rst_n && bus.m_start) begin
        n_start++;
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_start", 32'(1), 32'(0));
          e = '0;
        end else begin
          e = exp_q.pop_front();
          check("start_rw", 32'(bus.m_rw), 32'(e.rw));
          check("start_addr", 32'(bus.m_slave_addr), 32'(e.addr));
          check("start_data", 32'(bus.m_tx_data), 32'(e.data));
        end
        if (silent) begin
          @(negedge clk);
        end else begin
          repeat (stale_delay) @(negedge clk);
          bus.m_done = 1'b0; bus.m_ack_error = 1'b0;
          @(negedge clk);
          bus.m_busy = 1'b1;
          for (int k = 0; k < 3; k++) begin
            if (rst_n && !abort) begin
              check("hold_addr", 32'(bus.m_slave_addr), 32'(e.addr));
              check("hold_data", 32'(bus.m_tx_data), 32'(e.data));
              check("hold_start", 32'(bus.m_start), 32'(0));
            end
            @(negedge clk);
          end
          bus.m_busy = 1'b0; bus.m_done = 1'b1;
          bus.m_ack_error = e.nack; bus.m_rx_data = e.rx;
          @(negedge clk);
          bus.m_done = 1'b0; bus.m_ack_error = 1'b0;
        end
      end
    end
  end

  task automatic start_burst(input logic [6:0] addr, input logic [7:0] base, input logic [3:0] count,
                             input logic verify, input logic [15:0] nack_m, input logic [15:0] bad_m);
    logic [7:0] d, rx;
    exp_pass = 0; exp_fail = 0; exp_nack = 0; exp_last = '0;
    for (int i = 0; i < int'(count); i++) begin
      d = base + 8'(i);
      exp_q.push_back('{1'b0, addr, d, nack_m[i], 8'h00});
      if (nack_m[i]) begin
        exp_nack++; exp_fail++;
      end else if (!verify) begin
        exp_pass++;
      end else begin
        rx = ~d ^ (bad_m[i] ? 8'h5A : 8'h00);
        exp_q.push_back('{1'b1, addr, d, 1'b0, rx});
        exp_last = rx;
        if (bad_m[i]) exp_fail++; else exp_pass++;
      end
    end
    cfg_addr = addr; cfg_base_data = base; cfg_count = count; cfg_verify = verify;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("go_busy", 32'(busy), 32'(1));
    if (count != 4'd0) check("go_start", 32'(bus.m_start), 32'(1));
    else               check("zero_done", 32'(done), 32'(1));
  endtask

  task automatic finish_burst(input string tag, input bit exp_to);
    int n = 0;
    bit seen;
    seen = done;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      seen = done;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'(1));
    done_cyc = cyc;
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'({done, busy}), 32'(0));
    check({tag, "_pass"}, 32'(pass_cnt), 32'(exp_pass));
    check({tag, "_fail"}, 32'(fail_cnt), 32'(exp_fail));
    check({tag, "_nack"}, 32'(nack_cnt), 32'(exp_nack));
    check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
    check({tag, "_last_rx"}, 32'(last_rx), 32'(exp_last));
    if (exp_to) exp_q.delete();
    else check({tag, "_all_issued"}, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 32'({busy, done, bus.m_start, bus.m_rw, bus.m_slave_addr, bus.m_tx_data}), 32'(0));
    check("reset_status", 32'({pass_cnt, fail_cnt, nack_cnt, timeout, last_rx}), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    start_burst(7'h2A, 8'h10, 4'd3, 1'b0, 16'h0000, 16'h0000);
    finish_burst("plain", 1'b0);

    start_burst(7'h51, 8'h10, 4'd2, 1'b1, 16'h0000, 16'h0000);
    finish_burst("verify", 1'b0);
    check("verify_last_rx_ee", 32'(last_rx), 32'(8'hEE));

    start_burst(7'h51, 8'h10, 4'd3, 1'b1, 16'h0002, 16'h0000);
    finish_burst("nack", 1'b0);

    start_burst(7'h12, 8'h40, 4'd2, 1'b1, 16'h0000, 16'h0002);
    finish_burst("mismatch", 1'b0);

    start_burst(7'h7F, 8'hFE, 4'd3, 1'b1, 16'h0000, 16'h0000);
    finish_burst("wrap", 1'b0);

    n0 = n_start;
    start_burst(7'h05, 8'h33, 4'd0, 1'b0, 16'h0000, 16'h0000);
    finish_burst("zero", 1'b0);
    check("zero_no_start", 32'(n_start - n0), 32'(0));

    stale_on = 1'b1; stale_delay = 4;
    repeat (2) @(negedge clk);
    start_burst(7'h19, 8'hA0, 4'd1, 1'b0, 16'h0000, 16'h0000);
    finish_burst("stale", 1'b0);
    stale_on = 1'b0; stale_delay = 0;
    repeat (2) @(negedge clk);

    start_burst(7'h33, 8'h20, 4'd2, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    cfg_addr = 7'h01; cfg_base_data = 8'h99; cfg_count = 4'd5; cfg_verify = 1'b1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    finish_burst("early_go", 1'b0);

    silent = 1'b1;
    n0 = n_start;
    start_burst(7'h44, 8'h80, 4'd3, 1'b0, 16'h0000, 16'h0000);
    exp_pass = 0; exp_fail = 1; exp_nack = 0; exp_last = '0;
    finish_burst("timeout", 1'b1);
    check("timeout_one_start", 32'(n_start - n0), 32'(1));
    check("timeout_latency", 32'((done_cyc - start_cyc >= 100) && (done_cyc - start_cyc <= 102)), 32'(1));
    silent = 1'b0;
    repeat (5) @(negedge clk);
    check("timeout_hold", 32'({timeout, fail_cnt}), 32'({1'b1, 5'd1}));

    start_burst(7'h6C, 8'h01, 4'd5, 1'b1, 16'h0000, 16'h0000);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    abort = 1'b1;
    #1;
    check("rst_mid_ctrl", 32'({busy, done, bus.m_start, bus.m_rw, bus.m_slave_addr, bus.m_tx_data}), 32'(0));
    check("rst_mid_status", 32'({pass_cnt, fail_cnt, nack_cnt, timeout, last_rx}), 32'(0));
    exp_q.delete();
    n0 = n_start;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_no_start", 32'(n_start - n0), 32'(0));
    check("rst_idle", 32'({busy, done}), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
